// File: rtl/video_timing_gen.sv
// 800x600@60 video timing generator with a 3-stage output aligner for the TMDS path.
// Optional `VIDEO_BORDER_EN forces a 1-pixel white border onto the active picture.
module video_timing_gen #(
   parameter logic [10:0] H_SYNC  = 11'd128,
   parameter logic [10:0] H_BACK  = 11'd88,
   parameter logic [10:0] H_DISP  = 11'd800,
   parameter logic [10:0] H_FRONT = 11'd40,
   parameter logic [10:0] V_SYNC  = 11'd4,
   parameter logic [10:0] V_BACK  = 11'd23,
   parameter logic [10:0] V_DISP  = 11'd600,
   parameter logic [10:0] V_FRONT = 11'd1
) (
   input  logic        pixel_clk,
   input  logic        sys_rst_n,
   input  logic [23:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic        data_req,
   output logic        video_hs,
   output logic        video_vs,
   output logic        video_de,
   output logic [23:0] video_rgb,
   output logic        frame_start
);

   localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam logic [10:0] H_START = H_SYNC + H_BACK;
   localparam logic [10:0] V_START = V_SYNC + V_BACK;
   localparam logic [10:0] H_END   = H_START + H_DISP;
   localparam logic [10:0] V_END   = V_START + V_DISP;

   logic [10:0] h_cnt_p0, v_cnt_p0;
   logic        h_act_p0, v_act_p0, act_p0;
   logic [10:0] xpos_p1, ypos_p1;
   logic        vld_p1, hs_p1, vs_p1, fs_p1;
   logic        vld_p2, hs_p2, vs_p2, fs_p2;
`ifdef VIDEO_BORDER_EN
   logic [10:0] xpos_p2, ypos_p2;

   function automatic logic [23:0] out_rgb(input logic de, input logic [23:0] d,
                                           input logic [10:0] x, input logic [10:0] y);
      if (!de)
         return 24'd0;
      if (x == 11'd0 || x == H_DISP - 11'd1 || y == 11'd0 || y == V_DISP - 11'd1)
         return 24'hFFFFFF;
      return d;
   endfunction
`else
   function automatic logic [23:0] out_rgb(input logic de, input logic [23:0] d);
      return de ? d : 24'd0;
   endfunction
`endif

   // Stage p0: free-running line/frame counters
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else if (h_cnt_p0 == H_TOTAL - 11'd1) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= (v_cnt_p0 == V_TOTAL - 11'd1) ? 11'd0 : v_cnt_p0 + 11'd1;
      end else begin
         h_cnt_p0 <= h_cnt_p0 + 11'd1;
      end
   end

   assign h_act_p0 = (h_cnt_p0 >= H_START) && (h_cnt_p0 < H_END);
   assign v_act_p0 = (v_cnt_p0 >= V_START) && (v_cnt_p0 < V_END);
   assign act_p0   = h_act_p0 && v_act_p0;

   // Stage p1: pixel request towards the colour stage
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vld_p1  <= 1'b0;
         xpos_p1 <= '0;
         ypos_p1 <= '0;
         hs_p1   <= 1'b0;
         vs_p1   <= 1'b0;
         fs_p1   <= 1'b0;
      end else begin
         vld_p1  <= act_p0;
         xpos_p1 <= act_p0 ? h_cnt_p0 - H_START : 11'd0;
         ypos_p1 <= act_p0 ? v_cnt_p0 - V_START : 11'd0;
         hs_p1   <= h_cnt_p0 < H_SYNC;
         vs_p1   <= v_cnt_p0 < V_SYNC;
         fs_p1   <= (h_cnt_p0 == 11'd0) && (v_cnt_p0 == 11'd0);
      end
   end

   assign data_req   = vld_p1;
   assign pixel_xpos = xpos_p1;
   assign pixel_ypos = ypos_p1;

   // Stage p2: matches the colour stage's register
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vld_p2 <= 1'b0;
         hs_p2  <= 1'b0;
         vs_p2  <= 1'b0;
         fs_p2  <= 1'b0;
`ifdef VIDEO_BORDER_EN
         xpos_p2 <= '0;
         ypos_p2 <= '0;
`endif
      end else begin
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         fs_p2  <= fs_p1;
`ifdef VIDEO_BORDER_EN
         xpos_p2 <= xpos_p1;
         ypos_p2 <= ypos_p1;
`endif
      end
   end

   // Output stage: sync, enable and pixel leave together
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         video_hs    <= 1'b0;
         video_vs    <= 1'b0;
         video_de    <= 1'b0;
         video_rgb   <= '0;
         frame_start <= 1'b0;
      end else begin
         video_hs    <= hs_p2;
         video_vs    <= vs_p2;
         video_de    <= vld_p2;
`ifdef VIDEO_BORDER_EN
         video_rgb   <= out_rgb(vld_p2, pixel_data, xpos_p2, ypos_p2);
`else
         video_rgb   <= out_rgb(vld_p2, pixel_data);
`endif
         frame_start <= fs_p2;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster; reference positions come from edge counts.
module tb_video_timing_gen;

   localparam int P_HS = 8, P_HB = 6, P_HD = 20, P_HF = 4;
   localparam int P_VS = 2, P_VB = 3, P_VD = 10, P_VF = 1;
   localparam int HT = P_HS + P_HB + P_HD + P_HF;
   localparam int VT = P_VS + P_VB + P_VD + P_VF;
   localparam int FRAME = HT * VT;
   localparam int HA = P_HS + P_HB;
   localparam int VA = P_VS + P_VB;

   logic        pixel_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [23:0] pixel_data = '0;
   logic [10:0] pixel_xpos, pixel_ypos;
   logic        data_req, video_hs, video_vs, video_de, frame_start;
   logic [23:0] video_rgb;

   video_timing_gen #(
      .H_SYNC(11'(P_HS)), .H_BACK(11'(P_HB)), .H_DISP(11'(P_HD)), .H_FRONT(11'(P_HF)),
      .V_SYNC(11'(P_VS)), .V_BACK(11'(P_VB)), .V_DISP(11'(P_VD)), .V_FRONT(11'(P_VF))
   ) dut (
      .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .pixel_data(pixel_data),
      .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
      .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
      .video_rgb(video_rgb), .frame_start(frame_start)
   );

   always #5 pixel_clk = ~pixel_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int k;                       // rising edges since reset release
   logic        req_s;          // colour-stage register inputs captured last cycle
   logic [10:0] x_s, y_s;
   logic [1:0]  top_drv;        // random tag placed on the pixel currently driven
   int cnt_de, cnt_hs, cnt_vs, cnt_fs, cnt_burst;
   logic prev_de;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   function automatic bit is_act(input int h, input int v);
      return (h >= HA) && (h < HA + P_HD) && (v >= VA) && (v < VA + P_VD);
   endfunction

   task automatic check_zero(input string ph);
      chk({ph, "_req"},  32'(data_req),    32'd0);
      chk({ph, "_xpos"}, 32'(pixel_xpos),  32'd0);
      chk({ph, "_ypos"}, 32'(pixel_ypos),  32'd0);
      chk({ph, "_hs"},   32'(video_hs),    32'd0);
      chk({ph, "_vs"},   32'(video_vs),    32'd0);
      chk({ph, "_de"},   32'(video_de),    32'd0);
      chk({ph, "_rgb"},  32'(video_rgb),   32'd0);
      chk({ph, "_fs"},   32'(frame_start), 32'd0);
   endtask

   task automatic check_cycle();
      int h, v, n;
      bit a;
      logic [23:0] rgb;
      if (k >= 1) begin
         n = k - 1;
         h = n % HT;
         v = (n / HT) % VT;
         a = is_act(h, v);
         chk("data_req", 32'(data_req), 32'(a));
         chk("xpos", 32'(pixel_xpos), a ? h - HA : 0);
         chk("ypos", 32'(pixel_ypos), a ? v - VA : 0);
      end else begin
         chk("data_req", 32'(data_req), 32'd0);
      end
      if (k >= 3) begin
         n = k - 3;
         h = n % HT;
         v = (n / HT) % VT;
         a = is_act(h, v);
         rgb = a ? {top_drv, 11'(v - VA), 11'(h - HA)} : 24'd0;
`ifdef VIDEO_BORDER_EN
         if (a && (h == HA || h == HA + P_HD - 1 || v == VA || v == VA + P_VD - 1))
            rgb = 24'hFFFFFF;
`endif
         chk("hs",  32'(video_hs),    32'(h < P_HS));
         chk("vs",  32'(video_vs),    32'(v < P_VS));
         chk("de",  32'(video_de),    32'(a));
         chk("rgb", 32'(video_rgb),   32'(rgb));
         chk("fs",  32'(frame_start), 32'(n % FRAME == 0));
      end else begin
         chk("early_hs", 32'(video_hs), 32'd0);
         chk("early_de", 32'(video_de), 32'd0);
         chk("early_fs", 32'(frame_start), 32'd0);
      end
   endtask

   // Registered colour stage: {tag, ypos, xpos} for requested pixels, noise otherwise.
   task automatic drive_colour();
      logic [1:0] t;
      t = 2'($urandom);
      top_drv = t;
      pixel_data = req_s ? {t, y_s, x_s} : 24'($urandom);
      req_s = data_req;
      x_s = pixel_xpos;
      y_s = pixel_ypos;
   endtask

   task automatic release_reset();
      @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      k = 0;
      req_s = 1'b0;
      x_s = '0;
      y_s = '0;
   endtask

   task automatic run(input int cycles, input bit tally);
      for (int i = 0; i < cycles; i++) begin
         @(posedge pixel_clk);
         k++;
         #1;
         check_cycle();
         if (tally && k >= 3 && k < 3 + 2 * FRAME) begin
            cnt_de    += int'(video_de);
            cnt_hs    += int'(video_hs);
            cnt_vs    += int'(video_vs);
            cnt_fs    += int'(frame_start);
            cnt_burst += int'(video_de && !prev_de);
            prev_de = video_de;
         end
         drive_colour();
      end
   endtask

   task automatic mid_reset(input int pos);
      run(pos - k, 1'b0);
      #2 sys_rst_n = 1'b0;
      #1 check_zero("async_rst");
      pixel_data = 24'($urandom);
      repeat ($urandom_range(2, 6)) @(posedge pixel_clk);
      #1 check_zero("held_rst");
      release_reset();
      run(FRAME + 40, 1'b0);
   endtask

   initial begin
      k = 0;
      req_s = 1'b0;
      x_s = '0;
      y_s = '0;
      top_drv = '0;
      cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_burst = 0;
      prev_de = 1'b0;
      pixel_data = 24'($urandom);
      repeat (10) @(posedge pixel_clk);
      #1 check_zero("reset");

      release_reset();
      run(3 + 2 * FRAME + 50, 1'b1);
      chk("two_frame_de_cycles", 32'(cnt_de),    32'(2 * P_HD * P_VD));
      chk("two_frame_hs_cycles", 32'(cnt_hs),    32'(2 * VT * P_HS));
      chk("two_frame_vs_cycles", 32'(cnt_vs),    32'(2 * P_VS * HT));
      chk("two_frame_fs_pulses", 32'(cnt_fs),    32'd2);
      chk("two_frame_de_bursts", 32'(cnt_burst), 32'(2 * P_VD));

      // Reset in the middle of an active line, then at random positions.
      sys_rst_n = 1'b0;
      #1 check_zero("between_runs");
      release_reset();
      mid_reset((VA + P_VD / 2) * HT + HA + P_HD / 2);
      for (int r = 0; r < 3; r++)
         mid_reset(k + int'($urandom_range(1, FRAME)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
